// File: rtl/timer_ctrl.sv
// Bus-mapped sequencer for one counter timer: arm/run/done FSM, sticky tick interrupt, expiration count.
// Optional TIMER_CTRL_SHADOW_EN: counter config is shadowed and only applied when the timer is (re)armed.
module timer_ctrl #(
  parameter int CNT_W  = 16,
  parameter int TCNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic             we,
  input  logic [3:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             ready,
  output logic             tim_en,
  output logic             tim_reset,
  output logic             tim_up_down,
  output logic             tim_one_shot,
  output logic [CNT_W-1:0] tim_prescaler,
  output logic [CNT_W-1:0] tim_load,
  input  logic             tim_tick,
  output logic             irq
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t             state;
  logic               ctrl_en, ctrl_ud, ctrl_os, ctrl_irq_en;
  logic [CNT_W-1:0]   presc, load;
  logic               pend;
  logic [TCNT_W-1:0]  tcnt;
  logic [15:0]        tcnt16;
  logic [31:0]        rd_val;
  logic               acc, wr, rd;
  logic               wr_ctrl, wr_presc, wr_load, wr_status;
  logic               arm_req, idle_req, tick_run, running, unused;

  assign acc       = sel & ~ready;
  assign wr        = acc & we;
  assign rd        = acc & ~we;
  assign wr_ctrl   = wr & (addr[3:2] == 2'd0);
  assign wr_presc  = wr & (addr[3:2] == 2'd1);
  assign wr_load   = wr & (addr[3:2] == 2'd2);
  assign wr_status = wr & (addr[3:2] == 2'd3);
  assign arm_req   = wr_ctrl & wdata[0] & wdata[4];
  assign idle_req  = wr_ctrl & ~wdata[0];
  assign tick_run  = (state == RUN) & tim_tick;
  assign running   = (state == ARM) | (state == RUN);
  assign tcnt16    = 16'(tcnt);
  assign unused    = ^{addr[1:0], wdata};

  // Bus side: one access per two cycles when sel is held, ready is the completion strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= acc;
      rdata <= rd ? rd_val : '0;
    end
  end

  always_comb begin
    rd_val = '0;
    case (addr[3:2])
      2'd0: rd_val[3:0] = {ctrl_irq_en, ctrl_os, ctrl_ud, ctrl_en};
      2'd1: rd_val[CNT_W-1:0] = presc;
      2'd2: rd_val[CNT_W-1:0] = load;
      default: rd_val = {tcnt16, 13'd0, state == DONE, running, pend};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en     <= 1'b0;
      ctrl_ud     <= 1'b0;
      ctrl_os     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      presc       <= '0;
      load        <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en     <= wdata[0];
        ctrl_ud     <= wdata[1];
        ctrl_os     <= wdata[2];
        ctrl_irq_en <= wdata[3];
      end
      if (wr_presc) presc <= wdata[CNT_W-1:0];
      if (wr_load)  load  <= wdata[CNT_W-1:0];
    end
  end

`ifdef TIMER_CTRL_SHADOW_EN
  // Config registers act as shadows; the counter only sees them when a period is (re)armed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tim_prescaler <= '0;
      tim_load      <= '0;
      tim_up_down   <= 1'b0;
      tim_one_shot  <= 1'b0;
    end else if (arm_req) begin
      tim_prescaler <= presc;
      tim_load      <= load;
      tim_up_down   <= wdata[1];
      tim_one_shot  <= wdata[2];
    end
  end
`else
  assign tim_prescaler = presc;
  assign tim_load      = load;
  assign tim_up_down   = ctrl_ud;
  assign tim_one_shot  = ctrl_os;
`endif

  // Bus writes override the FSM; a disabling write wins over everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tim_en    <= 1'b0;
      tim_reset <= 1'b0;
    end else if (idle_req) begin
      state     <= IDLE;
      tim_en    <= 1'b0;
      tim_reset <= 1'b0;
    end else if (arm_req) begin
      state     <= ARM;
      tim_en    <= 1'b1;
      tim_reset <= 1'b1;
    end else begin
      tim_reset <= 1'b0;
      case (state)
        ARM: begin
          state  <= RUN;
          tim_en <= 1'b1;
        end
        RUN: begin
          if (tim_tick && tim_one_shot) begin
            state  <= DONE;
            tim_en <= 1'b0;
          end else begin
            tim_en <= 1'b1;
          end
        end
        default: tim_en <= 1'b0;
      endcase
    end
  end

  // A tick landing with a PEND clear keeps PEND set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
      tcnt <= '0;
      irq  <= 1'b0;
    end else begin
      if (tick_run)
        pend <= 1'b1;
      else if (wr_status && wdata[0])
        pend <= 1'b0;
`ifdef TIMER_CTRL_SHADOW_EN
      if (tick_run)
        tcnt <= tcnt + TCNT_W'(1);
`else
      if (wr_ctrl && wdata[5])
        tcnt <= '0;
      else if (tick_run)
        tcnt <= tcnt + TCNT_W'(1);
`endif
      irq <= pend & ctrl_irq_en;
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed bring-up steps, then randomized bus/tick traffic vs a register-level model.
module tb_timer_ctrl;
  localparam int CNT_W  = 16;
  localparam int TCNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n, sel, we, tim_tick;
  logic [3:0]       addr;
  logic [31:0]      wdata, rdata;
  logic             ready, tim_en, tim_reset, tim_up_down, tim_one_shot, irq;
  logic [CNT_W-1:0] tim_prescaler, tim_load;

  int checks = 0;
  int failures = 0;

  timer_ctrl #(.CNT_W(CNT_W), .TCNT_W(TCNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .tim_en(tim_en), .tim_reset(tim_reset),
    .tim_up_down(tim_up_down), .tim_one_shot(tim_one_shot),
    .tim_prescaler(tim_prescaler), .tim_load(tim_load), .tim_tick(tim_tick), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: programmer-visible registers plus what the counter should currently see
  logic [15:0] m_presc, m_load, m_tcnt, m_act_presc, m_act_load;
  bit          m_en, m_ud, m_os, m_irq_en, m_pend, m_run, m_done, m_act_ud, m_act_os;

  task automatic m_reset();
    m_presc = 0; m_load = 0; m_tcnt = 0; m_act_presc = 0; m_act_load = 0;
    m_en = 0; m_ud = 0; m_os = 0; m_irq_en = 0; m_pend = 0; m_run = 0; m_done = 0;
    m_act_ud = 0; m_act_os = 0;
  endtask

  task automatic m_write(input logic [3:0] a, input logic [31:0] d);
    case (a[3:2])
      2'd0: begin
        m_en = d[0]; m_ud = d[1]; m_os = d[2]; m_irq_en = d[3];
        if (!d[0]) begin
          m_run = 0; m_done = 0;
        end else if (d[4]) begin
          m_run = 1; m_done = 0;
          m_act_presc = m_presc; m_act_load = m_load; m_act_ud = d[1]; m_act_os = d[2];
        end
`ifndef TIMER_CTRL_SHADOW_EN
        if (d[5]) m_tcnt = 0;
`endif
      end
      2'd1: m_presc = d[15:0];
      2'd2: m_load = d[15:0];
      default: if (d[0]) m_pend = 0;
    endcase
`ifndef TIMER_CTRL_SHADOW_EN
    m_act_presc = m_presc; m_act_load = m_load; m_act_ud = m_ud; m_act_os = m_os;
`endif
  endtask

  task automatic m_tick();
    if (m_run) begin
      m_pend = 1;
      m_tcnt = m_tcnt + 16'd1;
      if (m_act_os) begin
        m_run = 0; m_done = 1;
      end
    end
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a[3:2])
      2'd0: return {28'd0, m_irq_en, m_os, m_ud, m_en};
      2'd1: return {16'd0, m_presc};
      2'd2: return {16'd0, m_load};
      default: return {m_tcnt, 13'd0, m_done, m_run, m_pend};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus access, optionally with a tick in the access cycle; ready must follow sel by one edge
  task automatic bus_access(input logic w, input logic [3:0] a, input logic [31:0] d,
                            input logic tick, output logic [31:0] rd);
    int lat;
    @(negedge clk);
    sel = 1; we = w; addr = a; wdata = d; tim_tick = tick;
    @(posedge clk); #1;
    lat = 1;
    while (!ready && lat < 4) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ready_latency", lat, 1);
    rd = rdata;
    @(negedge clk);
    sel = 0; we = 0; tim_tick = 0;
    if (w) m_write(a, d);
    if (tick) m_tick();
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic tick);
    logic [31:0] dummy;
    bus_access(1'b1, a, d, tick, dummy);
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_access(1'b0, a, 32'd0, 1'b0, v);
    check(tag, v, exp);
  endtask

  task automatic tick_once();
    @(negedge clk); tim_tick = 1;
    @(negedge clk); tim_tick = 0;
    m_tick();
  endtask

  task automatic settle_and_check();
    @(posedge clk); #1;
    check("tim_en", tim_en, m_run);
    check("irq", irq, m_pend & m_irq_en);
    check("tim_load", tim_load, m_act_load);
    check("tim_prescaler", tim_prescaler, m_act_presc);
    check("tim_up_down", tim_up_down, m_act_ud);
    check("tim_one_shot", tim_one_shot, m_act_os);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  a;
    int op;
    rst_n = 0; sel = 0; we = 0; addr = 0; wdata = 0; tim_tick = 0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_tim_en", tim_en, 0);
    check("rst_tim_reset", tim_reset, 0);
    check("rst_irq", irq, 0);
    check("rst_ready", ready, 0);
    check("rst_rdata", rdata, 0);
    check("rst_tim_cfg", {tim_up_down, tim_one_shot, tim_prescaler, tim_load}, 0);
    rst_n = 1;
    read_check("rst_status", 4'hC, 32'h0);

    // Basic periodic run with interrupt
    bus_write(4'h4, 32'd9, 0);
    bus_write(4'h8, 32'd16, 0);
    bus_write(4'h0, 32'h1B, 0);
    check("arm_tim_reset", tim_reset, 1);
    check("arm_tim_en", tim_en, 1);
    check("arm_presc", tim_prescaler, 9);
    check("arm_load", tim_load, 16);
    @(posedge clk); #1;
    check("run_tim_reset", tim_reset, 0);
    check("run_tim_en", tim_en, 1);
    repeat (3) tick_once();
    read_check("status_3ticks", 4'hC, 32'h0003_0003);
    check("irq_after_ticks", irq, 1);

    // One-shot restart; expiry moves to DONE, later ticks are ignored
    bus_write(4'h0, 32'h17, 0);
    tick_once();
    check("oneshot_tim_en", tim_en, 0);
    read_check("status_done", 4'hC, 32'h0004_0005);
    tick_once();
    read_check("status_done_ignore", 4'hC, 32'h0004_0005);

    // Tick and PEND clear in the same cycle: set wins
    bus_write(4'h0, 32'h19, 0);
    bus_write(4'hC, 32'h1, 1);
    read_check("pend_set_wins", 4'hC, 32'h0005_0003);
    bus_write(4'hC, 32'h1, 0);
    check("irq_hold_one_cycle", irq, 1);
    @(posedge clk); #1;
    check("irq_falls", irq, 0);
    read_check("pend_cleared", 4'hC, 32'h0005_0002);

    // Reconfigure LOAD while running
    bus_write(4'h8, 32'd40, 0);
    repeat (2) @(posedge clk);
    #1;
`ifdef TIMER_CTRL_SHADOW_EN
    check("load_running", tim_load, 16);
`else
    check("load_running", tim_load, 40);
`endif
    read_check("load_readback", 4'h8, 32'd40);
    bus_write(4'h0, 32'h19, 0);
    check("load_after_start", tim_load, 40);

    // TCNT_CLR bit (only meaningful without shadowing)
    bus_write(4'h0, 32'h29, 0);
    read_check("tcnt_clr", 4'hC, m_read(4'hC));

    // Randomized traffic against the model
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 6);
      d  = $urandom;
      case (op)
        0: bus_write(4'h4, d, 0);
        1: bus_write(4'h8, d, 0);
        2: begin
          d = d & 32'h3F;
          if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
          bus_write(4'h0, d, 0);
        end
        3: bus_write(4'hC, d, $urandom_range(0, 1) == 1);
        4: tick_once();
        5: begin
          a = 4'($urandom_range(0, 15));
          read_check("rand_read", a, m_read(a));
        end
        default: read_check("rand_status", 4'hC, m_read(4'hC));
      endcase
      settle_and_check();
    end

    // Asynchronous reset in the middle of a run
    bus_write(4'h0, 32'h19, 0);
    tick_once();
    @(posedge clk); #1;
    check("pre_rst_irq", irq, 1);
    check("pre_rst_en", tim_en, 1);
    #3;
    rst_n = 0;
    #1;
    check("async_rst_tim_en", tim_en, 0);
    check("async_rst_irq", irq, 0);
    check("async_rst_cfg", {tim_up_down, tim_one_shot, tim_prescaler, tim_load}, 0);
    @(negedge clk);
    rst_n = 1;
    m_reset();
    read_check("post_rst_status", 4'hC, 32'h0);
    read_check("post_rst_ctrl", 4'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
